full_stream_fifo: RTL and testbench



---
 rtl/full_stream_fifo_pkg.sv | 15 +
 rtl/full_stream_ram.sv | 28 ++
 rtl/full_stream_fifo.sv | 115 +++++++++++
 tb/tb_full_stream_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/full_stream_fifo_pkg.sv
// Shared types for the fully-connected layer stream FIFO.
package full_stream_fifo_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } float_24_8;

   typedef struct packed {
      logic      fst;
      float_24_8 data;
   } stream_word_t;

endpackage

// File: rtl/full_stream_ram.sv
// DEPTH x (WIDTH+1) register file: one synchronous write port, one asynchronous read port.
module full_stream_ram
   import full_stream_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH:0]    wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH:0]    rd_data
);

   logic [WIDTH:0] mem_q [DEPTH];

   // Storage is never reset; validity is tracked by the FIFO counters.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/full_stream_fifo.sv
// Stream FIFO of {fst, data} words with early-ready, occupancy and frame-count status.
module full_stream_fifo
   import full_stream_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_MARGIN = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_fst,
   input  logic                   in_vld,
   output logic                   in_rdy,
   output logic                   in_pre_rdy,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_fst,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [$clog2(DEPTH):0] level,
   output logic [$clog2(DEPTH):0] frames
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q,  level_d;
   logic [LVL_W-1:0] frames_q, frames_d;
   logic [LVL_W-1:0] free_slots;
   logic [WIDTH:0]   head_word;
   logic             head_fst;
   logic             wr_fire;
   logic             rd_fire;
   logic             clear;
   logic             ram_wr_en;

   // Handshake status derives only from registered occupancy: no in->out or out->in paths.
   assign free_slots = LVL_W'(DEPTH) - level_q;
   assign in_rdy     = (level_q != LVL_W'(DEPTH));
   assign in_pre_rdy = (free_slots > LVL_W'(AF_MARGIN));
   assign out_vld    = (level_q != '0);

   assign wr_fire   = in_vld  & in_rdy;
   assign rd_fire   = out_vld & out_rdy;
   assign clear     = reset | flush;
   assign ram_wr_en = wr_fire & ~clear;

   assign head_fst = head_word[WIDTH];
   assign out_fst  = head_fst;
   assign out_data = head_word[WIDTH-1:0];
   assign level    = level_q;
   assign frames   = frames_q;

   full_stream_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data ({in_fst, in_data}),
      .rd_addr (rd_ptr_q),
      .rd_data (head_word)
   );

   // Pointer and counter update; flush wins over any concurrent transfer.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      frames_d = frames_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         frames_d = '0;
      end else begin
         if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
         case ({wr_fire & in_fst, rd_fire & head_fst})
            2'b10:   frames_d = frames_q + LVL_W'(1);
            2'b01:   frames_d = frames_q - LVL_W'(1);
            default: frames_d = frames_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         frames_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         frames_q <= frames_d;
      end
   end

endmodule

// File: tb/tb_full_stream_fifo.sv
// Scoreboard bench for full_stream_fifo: directed fill/drain, threshold, frame, flush and streaming cases.
module tb_full_stream_fifo;
   import full_stream_fifo_pkg::*;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned DEPTH     = 8;
   localparam int unsigned AF_MARGIN = 2;

   logic              clk;
   logic              reset;
   logic              flush;
   logic [WIDTH-1:0]  in_data;
   logic              in_fst;
   logic              in_vld;
   logic              in_rdy;
   logic              in_pre_rdy;
   logic [WIDTH-1:0]  out_data;
   logic              out_fst;
   logic              out_vld;
   logic              out_rdy;
   logic [3:0]        level;
   logic [3:0]        frames;

   int                checks   = 0;
   int                failures = 0;
   stream_word_t      exp_q[$];
   int                m_lvl = 0;

   full_stream_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_MARGIN (AF_MARGIN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_data    (in_data),
      .in_fst     (in_fst),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_pre_rdy (in_pre_rdy),
      .out_data   (out_data),
      .out_fst    (out_fst),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .level      (level),
      .frames     (frames)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference occupancy model: decides acceptance and pushes expected words.
   always @(negedge clk) begin
      logic m_wr;
      logic m_rd;
      if (reset || flush) begin
         exp_q.delete();
         m_lvl = 0;
      end else begin
         chk("in_rdy_vs_model",  64'(in_rdy),  64'(m_lvl != int'(DEPTH)));
         chk("out_vld_vs_model", 64'(out_vld), 64'(m_lvl != 0));
         chk("level_vs_model",   64'(level),   64'(m_lvl));
         m_wr = in_vld  && (m_lvl != int'(DEPTH));
         m_rd = out_rdy && (m_lvl != 0);
         if (m_wr) exp_q.push_back({in_fst, in_data});
         m_lvl = m_lvl + int'(m_wr) - int'(m_rd);
      end
   end

   // Monitor: every accepted head word must match the oldest expected word.
   always @(negedge clk) begin
      stream_word_t w;
      if (!reset && !flush && out_vld && out_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=0x%0h required=none", {out_fst, out_data});
         end else begin
            w = exp_q.pop_front();
            chk("sb_word", 64'({out_fst, out_data}), 64'(w));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  v_fst [5];
      logic [7:0]  lfsr;
      int          idx;
      int          max_lvl;
      logic        acc;

      reset   = 1'b1;
      flush   = 1'b0;
      in_data = '0;
      in_fst  = 1'b0;
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_in_rdy",     64'(in_rdy),     64'd1);
      chk("rst_in_pre_rdy", 64'(in_pre_rdy), 64'd1);
      chk("rst_out_vld",    64'(out_vld),    64'd0);
      chk("rst_level",      64'(level),      64'd0);
      chk("rst_frames",     64'(frames),     64'd0);

      // Fill to full with the consumer stalled; watch the early-ready threshold.
      in_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h3F80_0000 + 32'(i);
         in_fst  = (i == 0);
         step();
         if (i == 4) chk("pre_rdy_after_5", 64'(in_pre_rdy), 64'd1);
         if (i == 5) begin
            chk("pre_rdy_after_6", 64'(in_pre_rdy), 64'd0);
            chk("rdy_after_6",     64'(in_rdy),     64'd1);
         end
         if (i == 6) chk("rdy_after_7", 64'(in_rdy), 64'd1);
      end
      in_vld = 1'b0;
      chk("full_in_rdy", 64'(in_rdy), 64'd0);
      chk("full_level",  64'(level),  64'd8);
      chk("full_frames", 64'(frames), 64'd1);

      // Full with simultaneous read and write: write rejected, then accepted.
      in_vld  = 1'b1;
      in_data = 32'h0000_AAAA;
      in_fst  = 1'b0;
      out_rdy = 1'b1;
      step();
      chk("full_rw_level", 64'(level),  64'd7);
      chk("full_rw_rdy",   64'(in_rdy), 64'd1);
      out_rdy = 1'b0;
      step();
      chk("refill_level", 64'(level), 64'd8);
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      for (int k = 0; k < 20 && out_vld; k++) step();
      out_rdy = 1'b0;
      chk("drain_out_vld", 64'(out_vld), 64'd0);
      chk("drain_level",   64'(level),   64'd0);
      chk("drain_frames",  64'(frames),  64'd0);

      // Frame counting over a 3-word then a 2-word vector.
      v_fst[0] = 2'd1; v_fst[1] = 2'd0; v_fst[2] = 2'd0; v_fst[3] = 2'd1; v_fst[4] = 2'd0;
      in_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 32'h4000_0000 + 32'(i);
         in_fst  = v_fst[i][0];
         step();
      end
      in_vld = 1'b0;
      chk("frames_two_vec", 64'(frames), 64'd2);
      chk("level_two_vec",  64'(level),  64'd5);
      out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) step();
      out_rdy = 1'b0;
      chk("frames_after_3rd", 64'(frames),   64'd1);
      chk("head4_fst",        64'(out_fst),  64'd1);
      chk("head4_data",       64'(out_data), 64'h4000_0003);
      chk("level_after_3rd",  64'(level),    64'd2);

      // Flush mid-stream with a concurrent write and read.
      in_vld = 1'b1;
      in_fst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h4040_0000 + 32'(i);
         step();
      end
      chk("pre_flush_level", 64'(level), 64'd5);
      flush   = 1'b1;
      in_data = 32'h0000_DEAD;
      in_fst  = 1'b1;
      out_rdy = 1'b1;
      step();
      flush   = 1'b0;
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      chk("flush_level",   64'(level),   64'd0);
      chk("flush_frames",  64'(frames),  64'd0);
      chk("flush_out_vld", 64'(out_vld), 64'd0);
      chk("flush_in_rdy",  64'(in_rdy),  64'd1);
      in_vld  = 1'b1;
      in_data = 32'h1234_5678;
      in_fst  = 1'b1;
      step();
      in_vld = 1'b0;
      chk("post_flush_level",  64'(level),    64'd1);
      chk("post_flush_head",   64'(out_data), 64'h1234_5678);
      chk("post_flush_frames", 64'(frames),   64'd1);
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      chk("post_flush_empty", 64'(out_vld), 64'd0);

      // Wrap-around streaming with a pseudo-random consumer.
      lfsr    = 8'hA5;
      idx     = 0;
      max_lvl = 0;
      for (int cyc = 0; cyc < 2000 && idx < 100; cyc++) begin
         lfsr    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         out_rdy = lfsr[0] | lfsr[2];
         in_vld  = 1'b1;
         in_data = 32'h0000_1000 + 32'(idx);
         in_fst  = (idx % 4 == 0);
         @(negedge clk);
         acc = in_rdy;
         step();
         if (acc) idx++;
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      in_vld = 1'b0;
      chk("stream_all_sent", 64'(idx), 64'd100);
      out_rdy = 1'b1;
      for (int k = 0; k < 50 && out_vld; k++) begin
         step();
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      out_rdy = 1'b0;
      chk("stream_max_level", 64'(max_lvl <= int'(DEPTH)), 64'd1);
      chk("stream_end_level", 64'(level),  64'd0);
      chk("stream_end_frames", 64'(frames), 64'd0);
      step();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
